vga_timing_receiver: RTL and testbench

- Receive end of the VGA link: consumes the hsync, vsync and rgb stream produced by the display path, plus the pixel-enable tick.
- Recovers pixel coordinates, locks onto the expected 640x480 timing and emits a per-pixel valid strobe with the captured colour.
- Flags any timing violation.
- Used as an in-fabric loopback checker and frame-capture front end next to the VGA controller.

---
 rtl/vga_timing_receiver.sv | 153 +++++++++++++++
 tb/tb_vga_timing_receiver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_receiver.sv
// VGA receive-side timing recovery: sync edge tracking, lock FSM,
// per-pixel valid strobe with captured colour and violation flag.
module vga_timing_receiver #(
   parameter int H_TOTAL         = 800,
   parameter int H_START         = 144,
   parameter int H_ACTIVE        = 640,
   parameter int V_TOTAL         = 525,
   parameter int V_START         = 35,
   parameter int V_ACTIVE        = 480,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int LOCK_FRAMES     = 2
) (
   input  logic        clk_100MHz,
   input  logic        reset,
   input  logic        p_tick,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [11:0] rgb,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic [11:0] rgb_out,
   output logic        pixel_valid,
   output logic        frame_start,
   output logic        locked,
   output logic        timing_error
);

   localparam logic [9:0] L_MAX   = 10'h3FF;
   localparam logic [9:0] L_HT    = 10'(H_TOTAL);
   localparam logic [9:0] L_HT_M1 = 10'(H_TOTAL - 1);
   localparam logic [9:0] L_HS    = 10'(H_START);
   localparam logic [9:0] L_HE    = 10'(H_START + H_ACTIVE);
   localparam logic [9:0] L_VT    = 10'(V_TOTAL);
   localparam logic [9:0] L_VT_M1 = 10'(V_TOTAL - 1);
   localparam logic [9:0] L_VS    = 10'(V_START);
   localparam logic [9:0] L_VE    = 10'(V_START + V_ACTIVE);
   localparam logic [7:0] L_LOCK  = 8'(LOCK_FRAMES);
   localparam logic       L_POL   = (SYNC_ACTIVE_LOW != 0);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   state_t      r_state;
   logic [9:0]  r_hcnt, r_vcnt, r_x, r_y;
   logic [11:0] r_rgb;
   logic [7:0]  r_good;
   logic        r_hs_prev, r_vs_prev, r_vs_pend;
   logic        r_pv, r_fs, r_locked, r_err;

   logic       w_hs, w_vs, w_hs_edge, w_vs_edge, w_pend, w_fs;
   logic [9:0] w_hinc, w_vinc, w_hnext, w_vnext;
   logic       w_line_bad, w_frm_chk, w_frm_good, w_frm_bad;
   logic       w_h_ovr, w_v_ovr, w_viol, w_active;
   logic [7:0] w_good_inc;

   assign w_hs      = hsync ^ L_POL;
   assign w_vs      = vsync ^ L_POL;
   assign w_hs_edge = w_hs & ~r_hs_prev;
   assign w_vs_edge = w_vs & ~r_vs_prev;
   // A vsync edge coinciding with an hsync edge is consumed at once
   assign w_pend    = r_vs_pend | w_vs_edge;
   assign w_fs      = w_hs_edge & w_pend;

   assign w_hinc  = (r_hcnt == L_MAX) ? L_MAX : r_hcnt + 10'd1;
   assign w_vinc  = (r_vcnt == L_MAX) ? L_MAX : r_vcnt + 10'd1;
   assign w_hnext = w_hs_edge ? 10'd0 : w_hinc;
   assign w_vnext = w_fs ? 10'd0 : (w_hs_edge ? w_vinc : r_vcnt);

   assign w_line_bad = w_hs_edge & (r_hcnt != L_MAX) & (r_hcnt != L_HT_M1);
   assign w_frm_chk  = w_fs & (r_vcnt != L_MAX);
   assign w_frm_good = w_frm_chk & (r_vcnt == L_VT_M1);
   assign w_frm_bad  = w_frm_chk & (r_vcnt != L_VT_M1);
   // Overrun fires only on the step that lands on the total
   assign w_h_ovr = ~w_hs_edge & (r_hcnt != L_MAX) & (w_hinc == L_HT);
   assign w_v_ovr = w_hs_edge & ~w_pend & (r_vcnt != L_MAX)
                  & (w_vinc == L_VT);
   assign w_viol  = w_line_bad | w_frm_bad | w_h_ovr | w_v_ovr;

   assign w_active = (w_hnext >= L_HS) & (w_hnext < L_HE)
                   & (w_vnext >= L_VS) & (w_vnext < L_VE);
   assign w_good_inc = r_good + 8'd1;

   always_ff @(posedge clk_100MHz) begin
      if (!reset) begin
         r_state   <= SEARCH;
         r_hcnt    <= L_MAX;
         r_vcnt    <= L_MAX;
         r_hs_prev <= 1'b0;
         r_vs_prev <= 1'b0;
         r_vs_pend <= 1'b0;
         r_good    <= 8'd0;
         r_x       <= 10'd0;
         r_y       <= 10'd0;
         r_rgb     <= 12'd0;
         r_pv      <= 1'b0;
         r_fs      <= 1'b0;
         r_locked  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_pv  <= 1'b0;
         r_fs  <= 1'b0;
         r_err <= 1'b0;
         if (p_tick) begin
            r_hs_prev <= w_hs;
            r_vs_prev <= w_vs;
            r_vs_pend <= w_pend & ~w_fs;
            r_hcnt    <= w_hnext;
            r_vcnt    <= w_vnext;
            r_fs      <= w_fs;
            unique case (r_state)
               SEARCH: begin
                  if (w_fs) begin
                     r_state <= ACQUIRE;
                     r_good  <= 8'd0;
                  end
               end
               ACQUIRE: begin
                  if (w_viol) begin
                     r_state <= SEARCH;
                  end else if (w_frm_good) begin
                     r_good <= w_good_inc;
                     if (w_good_inc == L_LOCK) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                     end
                  end
               end
               LOCKED: begin
                  if (w_viol) begin
                     r_err    <= 1'b1;
                     r_locked <= 1'b0;
                     r_state  <= SEARCH;
                  end else if (w_active) begin
                     r_pv  <= 1'b1;
                     r_x   <= w_hnext - L_HS;
                     r_y   <= w_vnext - L_VS;
                     r_rgb <= rgb;
                  end
               end
               default: r_state <= SEARCH;
            endcase
         end
      end
   end

   assign x            = r_x;
   assign y            = r_y;
   assign rgb_out      = r_rgb;
   assign pixel_valid  = r_pv;
   assign frame_start  = r_fs;
   assign locked       = r_locked;
   assign timing_error = r_err;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver on a scaled-down 20x10 raster,
// with a second instance fed active-high syncs for comparison.
module tb_vga_timing_receiver;

   localparam int HT = 20, HS = 5, HA = 12;
   localparam int VT = 10, VS = 2, VA = 6;

   logic        clk_100MHz = 1'b0;
   logic        reset = 1'b0, p_tick = 1'b0;
   logic        hsync = 1'b1, vsync = 1'b1;
   logic        hsync_b = 1'b0, vsync_b = 1'b0;
   logic [11:0] rgb = '0;

   logic [9:0]  x, y, x_b, y_b;
   logic [11:0] rgb_out, rgb_out_b;
   logic        pixel_valid, frame_start, locked, timing_error;
   logic        pixel_valid_b, frame_start_b, locked_b, timing_error_b;

   int n_cmp = 0, n_mis = 0;
   int n_pix = 0, n_fs = 0, n_err = 0;
   int mark_pix = 0, mark_fs = 0, mark_err = 0;
   int cur_ln = 0, cur_i = 0, tick_no = 0;
   int err_ln = -1, err_i = -1;
   int last_fs = -1, fs_period = 0;
   logic [9:0]  first_x = '0, first_y = '0;
   logic [9:0]  last_x = '0, last_y = 10'h3FF;
   logic [11:0] first_rgb = '0, exp_px;
   logic [9:0]  exp_x;

   always #5 clk_100MHz = ~clk_100MHz;

   vga_timing_receiver #(
      .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
      .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA),
      .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
   ) dut (
      .clk_100MHz(clk_100MHz), .reset(reset), .p_tick(p_tick),
      .hsync(hsync), .vsync(vsync), .rgb(rgb),
      .x(x), .y(y), .rgb_out(rgb_out),
      .pixel_valid(pixel_valid), .frame_start(frame_start),
      .locked(locked), .timing_error(timing_error)
   );

   vga_timing_receiver #(
      .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
      .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA),
      .SYNC_ACTIVE_LOW(0), .LOCK_FRAMES(2)
   ) dut_b (
      .clk_100MHz(clk_100MHz), .reset(reset), .p_tick(p_tick),
      .hsync(hsync_b), .vsync(vsync_b), .rgb(rgb),
      .x(x_b), .y(y_b), .rgb_out(rgb_out_b),
      .pixel_valid(pixel_valid_b), .frame_start(frame_start_b),
      .locked(locked_b), .timing_error(timing_error_b)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Colour at raster sample i of line ln is {ln, i}
   always @(negedge clk_100MHz) begin
      if (pixel_valid) begin
         exp_px = {6'(y + 10'(VS)), 6'(x + 10'(HS))};
         exp_x  = (y == last_y) ? last_x + 10'd1 : 10'd0;
         check("pix_rgb", 32'(rgb_out), 32'(exp_px));
         check("pix_step", 32'(x), 32'(exp_x));
         if (n_pix == mark_pix) begin
            first_x   = x;
            first_y   = y;
            first_rgb = rgb_out;
         end
         last_x = x;
         last_y = y;
         n_pix++;
      end
      if (pixel_valid | pixel_valid_b) begin
         check("inv_pv", 32'(pixel_valid_b), 32'(pixel_valid));
         check("inv_pix", {x_b, y_b, rgb_out_b}, {x, y, rgb_out});
      end
      if (frame_start | frame_start_b)
         check("inv_fs", 32'(frame_start_b), 32'(frame_start));
      if (timing_error | timing_error_b)
         check("inv_err", 32'(timing_error_b), 32'(timing_error));
      if (frame_start) begin
         n_fs++;
         if (last_fs >= 0) fs_period = tick_no - last_fs;
         last_fs = tick_no;
      end
      if (timing_error) begin
         n_err++;
         err_ln = cur_ln;
         err_i  = cur_i;
      end
   end

   task automatic rst_check(input string tag);
      check({tag, "_xy"}, {x, y}, 32'd0);
      check({tag, "_out"}, {rgb_out, pixel_valid, frame_start,
                           locked, timing_error}, 32'd0);
      check({tag, "_b"}, {x_b, y_b, pixel_valid_b, locked_b}, 32'd0);
   endtask

   task automatic mark();
      mark_pix = n_pix;
      mark_fs  = n_fs;
      mark_err = n_err;
   endtask

   task automatic send_line(input int ln, input int len,
                            input bit vs_on, input bit stall);
      logic [5:0] l6;
      l6 = 6'(ln);
      for (int i = 0; i < len; i++) begin
         if (stall && i == 8) begin
            repeat (100) @(posedge clk_100MHz);
            #1;
            check("stall_hold", {x, y}, {10'd2, 10'd2});
            check("stall_pv", 32'(pixel_valid), 32'd0);
         end
         cur_ln  = ln;
         cur_i   = i;
         hsync_b = (i < 3);
         vsync_b = vs_on;
         hsync   = ~hsync_b;
         vsync   = ~vsync_b;
         rgb     = {l6, 6'(i)};
         tick_no++;
         p_tick = 1'b1;
         @(posedge clk_100MHz);
         #1;
         p_tick = 1'b0;
         @(posedge clk_100MHz);
         #1;
      end
   endtask

   task automatic send_frame(input int bad_ln, input int bad_len,
                             input bit do_vs, input int stall_ln,
                             input int rst_ln);
      for (int ln = 0; ln < VT; ln++) begin
         if (ln == rst_ln) begin
            check("pre_rst_lock", 32'(locked), 32'd1);
            reset = 1'b0;
            @(posedge clk_100MHz);
            #1;
            rst_check("mid_rst");
            reset = 1'b1;
         end
         send_line(ln, (ln == bad_ln) ? bad_len : HT,
                   do_vs && ln < 2, ln == stall_ln);
      end
   endtask

   task automatic good_frame();
      send_frame(-1, HT, 1'b1, -1, -1);
   endtask

   initial begin
      repeat (3) @(posedge clk_100MHz);
      #1;
      rst_check("rst");
      reset = 1'b1;

      good_frame();
      good_frame();
      check("acq_locked", 32'(locked), 32'd0);
      check("acq_fs", 32'(n_fs), 32'd2);

      mark();
      good_frame();
      check("lock_rise", 32'(locked), 32'd1);
      check("lock_inv", 32'(locked_b), 32'd1);
      check("c_pix", 32'(n_pix - mark_pix), 32'd72);
      check("c_first_xy", {first_x, first_y}, 32'd0);
      check("c_first_rgb", 32'(first_rgb), 32'h085);
      check("c_last_xy", {last_x, last_y}, {10'd11, 10'd5});
      check("c_fs", 32'(n_fs - mark_fs), 32'd1);
      check("c_err", 32'(n_err - mark_err), 32'd0);

      mark();
      send_frame(-1, HT, 1'b1, 4, -1);
      check("d_pix", 32'(n_pix - mark_pix), 32'd72);
      check("d_fs_period", 32'(fs_period), 32'(HT * VT));
      check("d_locked", 32'(locked), 32'd1);

      mark();
      send_frame(4, HT - 1, 1'b1, -1, -1);
      check("short_err", 32'(n_err - mark_err), 32'd1);
      check("short_pos", 32'(err_ln * 100 + err_i), 32'd500);
      check("short_pix", 32'(n_pix - mark_pix), 32'd36);
      check("short_lock", 32'(locked), 32'd0);

      mark();
      good_frame();
      good_frame();
      check("relock_early", 32'(locked), 32'd0);
      check("relock_nopix", 32'(n_pix - mark_pix), 32'd0);
      mark();
      good_frame();
      check("relock", 32'(locked), 32'd1);
      check("relock_pix", 32'(n_pix - mark_pix), 32'd72);

      mark();
      send_frame(-1, HT, 1'b0, -1, -1);
      check("novs_err", 32'(n_err - mark_err), 32'd1);
      check("novs_pos", 32'(err_ln * 100 + err_i), 32'd0);
      check("novs_fs", 32'(n_fs - mark_fs), 32'd0);
      check("novs_lock", 32'(locked), 32'd0);

      mark();
      good_frame();
      send_frame(3, HT - 2, 1'b1, -1, -1);
      check("glitch_err", 32'(n_err - mark_err), 32'd0);
      check("glitch_lock", 32'(locked), 32'd0);
      good_frame();
      check("glitch_search", 32'(locked), 32'd0);
      good_frame();
      check("glitch_acq", 32'(locked), 32'd0);
      check("glitch_nopix", 32'(n_pix - mark_pix), 32'd0);
      mark();
      good_frame();
      check("glitch_relock", 32'(locked), 32'd1);
      check("glitch_pix", 32'(n_pix - mark_pix), 32'd72);

      send_frame(-1, HT, 1'b1, -1, 4);
      mark();
      good_frame();
      good_frame();
      check("rst_relock_early", 32'(locked), 32'd0);
      check("rst_nopix", 32'(n_pix - mark_pix), 32'd0);
      mark();
      good_frame();
      check("rst_relock", 32'(locked), 32'd1);
      check("rst_pix", 32'(n_pix - mark_pix), 32'd72);
      check("total_err", 32'(n_err), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_mis);
      $finish;
   end

endmodule
